// File: rtl/freq_meas_sched.sv
// Round-robin scheduler for one shared gated clock counter; scales counts to Hz.
// Optional FREQ_SCHED_AVG_EN: four gate passes per grant, averaged result.
module freq_meas_sched #(
    parameter int SEL_W      = 2,
    parameter int CW         = 32,
    parameter int GATE_CYC   = 100000,
    parameter int SETTLE_CYC = 8,
    parameter int SYNC_CYC   = 4,
    parameter int SCALE      = 1000
) (
    input  logic                  I_ref_clk,
    input  logic                  reset,
    input  logic                  I_enable,
    input  logic [2**SEL_W-1:0]   I_req,
    output logic                  O_busy,
    output logic [SEL_W-1:0]      O_sel,
    output logic                  O_cnt_clr,
    output logic                  O_gate,
    input  logic [CW-1:0]         I_count,
    output logic                  O_res_valid,
    input  logic                  I_res_ready,
    output logic [SEL_W-1:0]      O_res_ch,
    output logic [CW-1:0]         O_res_freq,
    output logic                  O_res_ovf
);
    localparam int N_CH = 2**SEL_W;
    localparam logic [31:0] SETTLE_LD = 32'(SETTLE_CYC - 1);
    localparam logic [31:0] GATE_LD   = 32'(GATE_CYC - 1);
    localparam logic [31:0] SYNC_LD   = 32'(SYNC_CYC - 1);
`ifdef FREQ_SCHED_AVG_EN
    localparam int ACC_W = CW + 2;
`else
    localparam int ACC_W = CW;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_GATE,
        S_HOLD,
        S_CAPTURE,
        S_RESULT
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [SEL_W-1:0] res_ch_q, res_ch_d;
    logic [CW-1:0]    res_freq_q, res_freq_d;
    logic             res_ovf_q, res_ovf_d;
`ifdef FREQ_SCHED_AVG_EN
    logic [1:0]       pass_q, pass_d;
`endif

    logic             gnt_vld;
    logic [SEL_W-1:0] gnt_ch;
    logic [SEL_W-1:0] cand;
    logic [CW-1:0]    scaled;
    logic [2*CW-1:0]  prod;

    // Descending scan so the lowest offset from the pointer wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        cand    = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            cand = ptr_q + SEL_W'(i);
            if (I_req[cand]) begin
                gnt_vld = 1'b1;
                gnt_ch  = cand;
            end
        end
    end

    always_comb begin
`ifdef FREQ_SCHED_AVG_EN
        scaled = acc_q[ACC_W-1:2];
`else
        scaled = acc_q;
`endif
        prod = (2*CW)'(scaled) * (2*CW)'(SCALE);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        acc_d      = acc_q;
        res_ch_d   = res_ch_q;
        res_freq_d = res_freq_q;
        res_ovf_d  = res_ovf_q;
`ifdef FREQ_SCHED_AVG_EN
        pass_d     = pass_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (I_enable && gnt_vld) begin
                    state_d = S_SETTLE;
                    sel_d   = gnt_ch;
                    ptr_d   = gnt_ch + SEL_W'(1);
                    cnt_d   = SETTLE_LD;
                    acc_d   = '0;
`ifdef FREQ_SCHED_AVG_EN
                    pass_d  = '0;
`endif
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_GATE;
                    cnt_d   = GATE_LD;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_GATE: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = SYNC_LD;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    acc_d   = acc_q + ACC_W'(I_count);
                    state_d = S_CAPTURE;
`ifdef FREQ_SCHED_AVG_EN
                    // One-cycle settle between passes clears the counter.
                    if (pass_q != 2'd3) begin
                        pass_d  = pass_q + 2'd1;
                        state_d = S_SETTLE;
                        cnt_d   = '0;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_CAPTURE: begin
                state_d  = S_RESULT;
                res_ch_d = sel_q;
                if (|prod[2*CW-1:CW]) begin
                    res_freq_d = '1;
                    res_ovf_d  = 1'b1;
                end else begin
                    res_freq_d = prod[CW-1:0];
                    res_ovf_d  = 1'b0;
                end
            end
            S_RESULT: begin
                if (I_res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (!I_enable && (state_q == S_SETTLE || state_q == S_GATE ||
                          state_q == S_HOLD || state_q == S_CAPTURE)) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge I_ref_clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sel_q      <= '0;
            ptr_q      <= '0;
            acc_q      <= '0;
            res_ch_q   <= '0;
            res_freq_q <= '0;
            res_ovf_q  <= 1'b0;
`ifdef FREQ_SCHED_AVG_EN
            pass_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            acc_q      <= acc_d;
            res_ch_q   <= res_ch_d;
            res_freq_q <= res_freq_d;
            res_ovf_q  <= res_ovf_d;
`ifdef FREQ_SCHED_AVG_EN
            pass_q     <= pass_d;
`endif
        end
    end

    assign O_busy      = (state_q != S_IDLE);
    assign O_sel       = sel_q;
    assign O_gate      = (state_q == S_GATE);
    assign O_cnt_clr   = (state_q == S_IDLE) || (state_q == S_SETTLE) ||
                         (state_q == S_RESULT);
    assign O_res_valid = (state_q == S_RESULT);
    assign O_res_ch    = res_ch_q;
    assign O_res_freq  = res_freq_q;
    assign O_res_ovf   = res_ovf_q;
endmodule

// File: tb/tb_freq_meas_sched.sv
// Directed + randomized bench for freq_meas_sched with a round-robin/scaling model.
// Honours FREQ_SCHED_AVG_EN when defined for the DUT build.
module tb_freq_meas_sched;
    localparam int SEL_W = 2, CW = 32, GATE_CYC = 10;
    localparam int SETTLE_CYC = 2, SYNC_CYC = 2, SCALE = 1000;
`ifdef FREQ_SCHED_AVG_EN
    localparam int PASSES = 4;
`else
    localparam int PASSES = 1;
`endif
    localparam int LAT = SETTLE_CYC + GATE_CYC + SYNC_CYC + 2 +
                         (PASSES - 1) * (GATE_CYC + SYNC_CYC + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic [3:0]    I_req = '0;
    logic [31:0]   I_count = '0;
    logic          I_res_ready = 1'b0;
    logic          O_busy, O_cnt_clr, O_gate, O_res_valid, O_res_ovf;
    logic [1:0]    O_sel, O_res_ch;
    logic [31:0]   O_res_freq;

    int n_cmp = 0;
    int n_err = 0;
    int gate_hi = 0;
    int gate_pulse = 0;
    int valid_hi = 0;
    logic gate_prev = 1'b0;
    logic [1:0] m_ptr = '0;

    freq_meas_sched #(
        .SEL_W(SEL_W), .CW(CW), .GATE_CYC(GATE_CYC),
        .SETTLE_CYC(SETTLE_CYC), .SYNC_CYC(SYNC_CYC), .SCALE(SCALE)
    ) dut (
        .I_ref_clk(clk), .reset(reset), .I_enable(en), .I_req(I_req),
        .O_busy(O_busy), .O_sel(O_sel), .O_cnt_clr(O_cnt_clr),
        .O_gate(O_gate), .I_count(I_count), .O_res_valid(O_res_valid),
        .I_res_ready(I_res_ready), .O_res_ch(O_res_ch),
        .O_res_freq(O_res_freq), .O_res_ovf(O_res_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (O_gate) gate_hi <= gate_hi + 1;
        if (O_gate && !gate_prev) gate_pulse <= gate_pulse + 1;
        gate_prev <= O_gate;
        if (O_res_valid) valid_hi <= valid_hi + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] ptr);
        for (int i = 0; i < 4; i++) begin
            int c;
            c = (int'(ptr) + i) % 4;
            if (req[c]) return 2'(c);
        end
        return ptr;
    endfunction

    task automatic run_meas(input logic [3:0] req, input logic [31:0] cnt,
                            input int rdy_dly, input bit drop);
        logic [1:0]  ech, ch_s;
        logic [31:0] ef, f_s;
        logic        eovf, o_s;
        logic [63:0] p;
        int          lat, g0, p0;
        bit          stable;
        ech   = rr_pick(req, m_ptr);
        m_ptr = ech + 2'd1;
        p     = 64'(cnt) * 64'(SCALE);
        if (p > 64'hFFFF_FFFF) begin
            ef = '1;
            eovf = 1'b1;
        end else begin
            ef = p[31:0];
            eovf = 1'b0;
        end
        g0 = gate_hi;
        p0 = gate_pulse;
        I_req = req;
        I_count = cnt;
        I_res_ready = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                chk("grant_sel", O_sel, ech);
                chk("settle_clr", O_cnt_clr, 1);
            end
            if (drop && lat == 2) I_req = '0;
        end while (!O_res_valid && lat < 200);
        chk("latency", lat, LAT);
        chk("res_ch", O_res_ch, ech);
        chk("res_freq", O_res_freq, ef);
        chk("res_ovf", O_res_ovf, eovf);
        chk("gate_cycles", gate_hi - g0, GATE_CYC * PASSES);
        chk("gate_pulses", gate_pulse - p0, PASSES);
        ch_s = O_res_ch;
        f_s = O_res_freq;
        o_s = O_res_ovf;
        p0 = gate_pulse;
        stable = 1'b1;
        repeat (rdy_dly) begin
            @(negedge clk);
            if (!O_res_valid || O_res_ch !== ch_s || O_res_freq !== f_s ||
                O_res_ovf !== o_s || O_gate || !O_cnt_clr)
                stable = 1'b0;
        end
        chk("stall_stable", stable, 1);
        chk("stall_nogate", gate_pulse - p0, 0);
        I_res_ready = 1'b1;
        @(negedge clk);
        chk("valid_drop", O_res_valid, 0);
        I_res_ready = 1'b0;
        I_req = '0;
    endtask

    initial begin
        int lat, v0;
        logic [1:0] ech;
        logic [3:0] rq;
        logic [31:0] rc;

        repeat (3) @(negedge clk);
        chk("rst_sel", O_sel, 0);
        chk("rst_clr", O_cnt_clr, 1);
        chk("rst_gate", O_gate, 0);
        chk("rst_busy", O_busy, 0);
        chk("rst_valid", O_res_valid, 0);
        chk("rst_ch", O_res_ch, 0);
        chk("rst_freq", O_res_freq, 0);
        chk("rst_ovf", O_res_ovf, 0);
        reset = 1'b0;
        en = 1'b1;
        @(negedge clk);

        repeat (5) run_meas(4'b1111, 32'd1234, 0, 1'b0);
        run_meas(4'b0100, 32'd37, 0, 1'b0);
        run_meas(4'b0001, 32'hFFFF_FFFF, 0, 1'b0);
        run_meas(4'b0001, 32'd4294967, 0, 1'b0);
        run_meas(4'b0010, 32'd123, 50, 1'b0);
        run_meas(4'b1000, 32'd5, 2, 1'b1);

        ech = rr_pick(4'b0100, m_ptr);
        m_ptr = ech + 2'd1;
        v0 = valid_hi;
        I_req = 4'b0100;
        I_count = 32'd77;
        for (lat = 1; lat <= SETTLE_CYC + 5; lat++) @(negedge clk);
        chk("abort_gate_on", O_gate, 1);
        en = 1'b0;
        @(negedge clk);
        chk("abort_gate", O_gate, 0);
        chk("abort_clr", O_cnt_clr, 1);
        chk("abort_busy", O_busy, 0);
        I_req = '0;
        repeat (20) @(negedge clk);
        chk("abort_novalid", valid_hi - v0, 0);
        en = 1'b1;
        run_meas(4'b1111, 32'd99, 1, 1'b0);

        I_req = 4'b0010;
        I_count = 32'd55;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mrst_busy", O_busy, 0);
        chk("mrst_gate", O_gate, 0);
        chk("mrst_clr", O_cnt_clr, 1);
        chk("mrst_sel", O_sel, 0);
        chk("mrst_valid", O_res_valid, 0);
        I_req = '0;
        @(negedge clk);
        reset = 1'b0;
        m_ptr = '0;
        v0 = valid_hi;
        repeat (5) @(negedge clk);
        chk("mrst_noresult", valid_hi - v0, 0);
        run_meas(4'b1111, 32'd42, 0, 1'b0);

        for (int k = 0; k < 20; k++) begin
            rq = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 1) == 1) rc = $urandom;
            else rc = 32'($urandom_range(0, 5000000));
            run_meas(rq, rc, $urandom_range(0, 4), ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
